// File: rtl/xadc_drp_arbiter_pkg.sv
// Shared types and constants for the XADC DRP arbiter.
// State encoding, DRP register addresses and a range helper.
package xadc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    RECOVER = 3'd4
  } state_t;

  localparam logic [6:0] ADDR_VPVN = 7'h03;
  localparam logic [6:0] ADDR_CFG0 = 7'h40;
  localparam logic [6:0] ADDR_CFG1 = 7'h41;
  localparam logic [6:0] ADDR_CFG2 = 7'h42;

  function automatic logic in_range(
    input logic [6:0] a,
    input logic [6:0] lo,
    input logic [6:0] hi
  );
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/xadc_drp_arbiter_if.sv
// Requester and XADC DRP signal bundle for the arbiter.
// slave = arbiter side, master = requesters plus XADC side.
interface xadc_drp_arbiter_if;

  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_ack;
  logic        req_err;
  logic [15:0] req_rdata;
  logic        xadc_busy;
  logic        drp_den;
  logic        drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic [7:0]  timeout_count;

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    input  xadc_busy,
    input  drp_do,
    input  drp_drdy,
    output req_ack,
    output req_err,
    output req_rdata,
    output drp_den,
    output drp_dwe,
    output drp_daddr,
    output drp_di,
    output timeout_count
  );

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    output xadc_busy,
    output drp_do,
    output drp_drdy,
    input  req_ack,
    input  req_err,
    input  req_rdata,
    input  drp_den,
    input  drp_dwe,
    input  drp_daddr,
    input  drp_di,
    input  timeout_count
  );

endinterface

// File: rtl/xadc_drp_arbiter_picker.sv
// Two-way round-robin grant: on a tie the requester
// that did not win last time is chosen.
module drp_rr_picker (
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic       o_any,
  output logic       o_idx
);

  always_comb begin
    o_any = |i_valid;
    o_idx = 1'b0;
    unique case (1'b1)
      (i_valid == 2'b11): o_idx = ~i_last;
      (i_valid == 2'b10): o_idx = 1'b1;
      (i_valid == 2'b01): o_idx = 1'b0;
      (i_valid == 2'b00): o_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/xadc_drp_arbiter.sv
// Round-robin owner of the XADC DRP: one transaction at a time,
// config writes held off while BUSY, DRDY timeout with recovery.
module xadc_drp_arbiter
  import xadc_pkg::*;
#(
  parameter int         TIMEOUT = 255,
  parameter logic [6:0] CFG_LO  = 7'h40,
  parameter logic [6:0] CFG_HI  = 7'h42
) (
  input logic               clk,
  input logic               rst_n,
  xadc_drp_arbiter_if.slave bus
);

  localparam logic [15:0] LP_TMAX = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_drdy_q;
  logic [15:0] r_do_q;
  logic        r_busy_q;

  logic        r_last;
  logic        r_gnt;
  logic        r_we;
  logic [6:0]  r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_timer;

  logic        r_den;
  logic        r_dwe;
  logic [6:0]  r_daddr;
  logic [15:0] r_di;
  logic [1:0]  r_ack;
  logic        r_err;
  logic [15:0] r_rdata;
  logic [7:0]  r_tocnt;

  logic        w_gnt_any;
  logic        w_gnt_idx;
  logic        w_sel_we;
  logic [6:0]  w_sel_addr;
  logic [15:0] w_sel_wdata;
  logic        w_hold;
  logic        w_tmo;
  logic [1:0]  w_ack_vec;

  logic        w_grant;
  logic        w_issue;
  logic        w_done;
  logic        w_tmo_hit;
  logic        w_tclr;
  logic        w_tinc;

  drp_rr_picker u_pick (
    .i_valid (bus.req_valid),
    .i_last  (r_last),
    .o_any   (w_gnt_any),
    .o_idx   (w_gnt_idx)
  );

  assign w_sel_we    = bus.req_we[w_gnt_idx];
  assign w_sel_addr  = w_gnt_idx ? bus.req_addr[13:7]
                                 : bus.req_addr[6:0];
  assign w_sel_wdata = w_gnt_idx ? bus.req_wdata[31:16]
                                 : bus.req_wdata[15:0];

  assign w_hold = w_sel_we && r_busy_q &&
                  in_range(w_sel_addr, CFG_LO, CFG_HI);

  assign w_tmo     = (r_timer == LP_TMAX);
  assign w_ack_vec = r_gnt ? 2'b10 : 2'b01;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    w_tmo_hit   = 1'b0;
    w_tclr      = 1'b0;
    w_tinc      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_gnt_any) begin
          w_grant     = 1'b1;
          w_state_nxt = w_hold ? HOLD : ISSUE;
        end
      end
      HOLD: begin
        if (!r_busy_q) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        w_issue     = 1'b1;
        w_tclr      = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (r_drdy_q) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_tmo) begin
          w_tmo_hit   = 1'b1;
          w_tclr      = 1'b1;
          w_state_nxt = RECOVER;
        end else begin
          w_tinc = 1'b1;
        end
      end
      // Late DRDY is swallowed here so it never reaches the next owner
      RECOVER: begin
        if (w_tmo) w_state_nxt = IDLE;
        else       w_tinc      = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drdy_q <= 1'b0;
      r_do_q   <= '0;
      r_busy_q <= 1'b0;
      r_last   <= 1'b1;
      r_gnt    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_timer  <= '0;
      r_den    <= 1'b0;
      r_dwe    <= 1'b0;
      r_daddr  <= '0;
      r_di     <= '0;
      r_ack    <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_tocnt  <= '0;
    end else begin
      r_drdy_q <= bus.drp_drdy;
      r_do_q   <= bus.drp_do;
      r_busy_q <= bus.xadc_busy;
      r_den    <= 1'b0;
      r_dwe    <= 1'b0;
      r_ack    <= '0;
      if (w_grant) begin
        r_gnt   <= w_gnt_idx;
        r_last  <= w_gnt_idx;
        r_we    <= w_sel_we;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
      if (w_issue) begin
        r_den   <= 1'b1;
        r_dwe   <= r_we;
        r_daddr <= r_addr;
        r_di    <= r_wdata;
      end
      if (w_tclr)      r_timer <= '0;
      else if (w_tinc) r_timer <= r_timer + 16'd1;
      if (w_done) begin
        r_ack   <= w_ack_vec;
        r_err   <= 1'b0;
        r_rdata <= r_do_q;
      end
      if (w_tmo_hit) begin
        r_ack   <= w_ack_vec;
        r_err   <= 1'b1;
        r_rdata <= '0;
        if (r_tocnt != 8'hFF) r_tocnt <= r_tocnt + 8'd1;
      end
    end
  end

  assign bus.drp_den       = r_den;
  assign bus.drp_dwe       = r_dwe;
  assign bus.drp_daddr     = r_daddr;
  assign bus.drp_di        = r_di;
  assign bus.req_ack       = r_ack;
  assign bus.req_err       = r_err;
  assign bus.req_rdata     = r_rdata;
  assign bus.timeout_count = r_tocnt;

endmodule
